// File: rtl/uart_reg_responder.sv
// Far-end UART command responder: parses W/R frames from received bytes, executes
// them on an internal 8-bit register file and answers with a single reply byte.
module uart_reg_responder #(
   parameter int unsigned NREG          = 16,
   parameter int unsigned AW            = 4,
   parameter int unsigned TIMEOUT_TICKS = 640,
   parameter logic [7:0]  ACK           = 8'h06,
   parameter logic [7:0]  NAK           = 8'h15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_tick,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic              rx_frame_error,
   input  logic              tx_done_tick,
   output logic              tx_start,
   output logic [7:0]        tx_din,
   output logic [NREG*8-1:0] regs_flat,
   output logic              wr_strobe,
   output logic [AW-1:0]     wr_addr,
   output logic              busy,
   output logic              overrun,
   output logic              timeout
);

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_ADDR, S_GET_DATA, S_EXEC, S_SEND, S_WAIT_TX
   } state_t;

   state_t        r_state;
   logic          r_is_wr;
   logic          r_err;
   logic [AW-1:0] r_addr;
   logic [7:0]    r_data;
   logic [7:0]    r_regs [NREG];
   logic [TW-1:0] r_tcnt;
   logic          r_tx_start;
   logic [7:0]    r_tx_din;
   logic          r_wr_strobe;
   logic [AW-1:0] r_wr_addr;
   logic          r_overrun;
   logic          r_timeout;

   logic          w_addr_ok;
   logic          w_tmo_hit;

   assign w_addr_ok = ({1'b0, rx_data} < 9'(NREG));
   assign w_tmo_hit = s_tick && (r_tcnt == TW'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_is_wr     <= 1'b0;
         r_err       <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_tcnt      <= '0;
         r_tx_start  <= 1'b0;
         r_tx_din    <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_overrun   <= 1'b0;
         r_timeout   <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         r_tx_start  <= 1'b0;
         r_wr_strobe <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (rx_done) begin
                  r_tcnt <= '0;
                  if (rx_frame_error || (rx_data != CMD_W && rx_data != CMD_R)) begin
                     r_err   <= 1'b1;
                     r_state <= S_EXEC;
                  end else begin
                     r_err   <= 1'b0;
                     r_is_wr <= (rx_data == CMD_W);
                     r_state <= S_GET_ADDR;
                  end
               end
            end
            S_GET_ADDR: begin
               // A byte landing on the final tick takes priority over the timeout.
               if (rx_done) begin
                  r_tcnt <= '0;
                  if (rx_frame_error || !w_addr_ok) begin
                     r_err   <= 1'b1;
                     r_state <= S_EXEC;
                  end else begin
                     r_addr  <= rx_data[AW-1:0];
                     r_state <= r_is_wr ? S_GET_DATA : S_EXEC;
                  end
               end else if (w_tmo_hit) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (s_tick) begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            S_GET_DATA: begin
               if (rx_done) begin
                  r_tcnt <= '0;
                  if (rx_frame_error) begin
                     r_err <= 1'b1;
                  end else begin
                     r_data      <= rx_data;
                     r_wr_strobe <= 1'b1;
                     r_wr_addr   <= r_addr;
                  end
                  r_state <= S_EXEC;
               end else if (w_tmo_hit) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (s_tick) begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            S_EXEC: begin
               if (r_err) begin
                  r_tx_din <= NAK;
               end else if (r_is_wr) begin
                  r_regs[r_addr] <= r_data;
                  r_tx_din       <= ACK;
               end else begin
                  r_tx_din <= r_regs[r_addr];
               end
               if (rx_done) r_overrun <= 1'b1;
               r_tx_start <= 1'b1;
               r_state    <= S_SEND;
            end
            S_SEND: begin
               if (rx_done) r_overrun <= 1'b1;
               r_state <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (rx_done) r_overrun <= 1'b1;
               if (tx_done_tick) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int unsigned i = 0; i < NREG; i++) regs_flat[8*i +: 8] = r_regs[i];
   end

   assign tx_start  = r_tx_start;
   assign tx_din    = r_tx_din;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign busy      = (r_state != S_IDLE);
   assign overrun   = r_overrun;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: frame-level reference model feeds expected
// replies and writes into queues; a monitor pops and compares whenever the DUT emits.
module tb_uart_reg_responder;

   localparam int NREG = 16;
   localparam int AW   = 4;
   localparam int TT   = 640;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              s_tick = 1'b1;
   logic [7:0]        rx_data = '0;
   logic              rx_done = 1'b0;
   logic              rx_frame_error = 1'b0;
   logic              tx_done_tick = 1'b0;
   logic              tx_start;
   logic [7:0]        tx_din;
   logic [NREG*8-1:0] regs_flat;
   logic              wr_strobe;
   logic [AW-1:0]     wr_addr;
   logic              busy;
   logic              overrun;
   logic              timeout;

   uart_reg_responder #(.NREG(NREG), .AW(AW), .TIMEOUT_TICKS(TT), .ACK(ACK), .NAK(NAK)) dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx_data(rx_data), .rx_done(rx_done),
      .rx_frame_error(rx_frame_error), .tx_done_tick(tx_done_tick), .tx_start(tx_start),
      .tx_din(tx_din), .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
      .busy(busy), .overrun(overrun), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct { logic [7:0] val; int cyc; } exp_t;
   exp_t txq[$];
   exp_t wq[$];
   logic [7:0] mregs [NREG];
   bit emu_busy = 1'b0;

   task automatic check(input string nm, input logic [NREG*8-1:0] act, input logic [NREG*8-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=1 expected=0 (t=%0t)", nm, $time);
   endtask

   // Monitor: every reply and every write strobe must match a queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (tx_start === 1'b1) begin
            if (txq.size() == 0) unexpected("unexpected_tx_start");
            else begin
               e = txq.pop_front();
               check("reply_byte", tx_din, e.val);
               check("reply_latency", cyc, e.cyc);
            end
         end
         if (wr_strobe === 1'b1) begin
            if (wq.size() == 0) unexpected("unexpected_wr_strobe");
            else begin
               e = wq.pop_front();
               check("wr_addr", wr_addr, e.val);
               check("wr_latency", cyc, e.cyc);
            end
         end
      end
   end

   // Models uart_tx: accepts tx_start, takes a while, pulses tx_done_tick.
   initial begin
      logic [7:0] held;
      int d;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1 && !reset) begin
            emu_busy = 1'b1;
            held = tx_din;
            d = $urandom_range(1, 12);
            repeat (d) begin
               @(negedge clk);
               if (reset) break;
               check("tx_din_stable", tx_din, held);
            end
            if (!reset) begin
               @(posedge clk); #1 tx_done_tick = 1'b1;
               @(posedge clk); #1 tx_done_tick = 1'b0;
            end
            emu_busy = 1'b0;
         end
      end
   end

   // Callers are positioned just after a rising edge; back-to-back calls give adjacent strobes.
   task automatic put_byte(input logic [7:0] b, input bit fe, output int n);
      rx_data = b;
      rx_frame_error = fe;
      rx_done = 1'b1;
      n = cyc;
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_frame_error = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || emu_busy) && t < 300) begin @(posedge clk); #1; t++; end
      if (t >= 300) unexpected("wait_idle_timeout");
   endtask

   task automatic check_regs(input string nm);
      logic [NREG*8-1:0] f;
      for (int i = 0; i < NREG; i++) f[8*i +: 8] = mregs[i];
      check(nm, regs_flat, f);
   endtask

   // Reference model at frame level: decide frame length, reply and effect from the bytes.
   task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [2:0] fe, input bit extra, input int gap);
      logic [7:0] bb [3];
      int nb, n, dummy;
      logic [7:0] rep;
      bit wr;
      exp_t e;
      bb[0] = b0; bb[1] = b1; bb[2] = b2;
      wr = 1'b0;
      if (fe[0] || (b0 != 8'h57 && b0 != 8'h52)) begin nb = 1; rep = NAK; end
      else if (fe[1] || int'(b1) >= NREG)        begin nb = 2; rep = NAK; end
      else if (b0 == 8'h52)                      begin nb = 2; rep = mregs[b1]; end
      else if (fe[2])                            begin nb = 3; rep = NAK; end
      else                                       begin nb = 3; rep = ACK; wr = 1'b1; end
      n = 0;
      for (int i = 0; i < nb; i++) begin
         put_byte(bb[i], fe[i], n);
         if (i < nb - 1) idle(gap < 0 ? $urandom_range(0, 4) : gap);
      end
      e.val = rep; e.cyc = n + 2; txq.push_back(e);
      if (wr) begin
         e.val = b1; e.cyc = n + 1; wq.push_back(e);
         mregs[b1] = b2;
      end
      if (extra) begin
         idle($urandom_range(0, 1));
         put_byte(8'($urandom), 1'b0, dummy);
      end
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int n, t;
      exp_t e;
      logic [7:0] cmd, addr;
      for (int i = 0; i < NREG; i++) mregs[i] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_tx_start", tx_start, 0);
      check("reset_busy", busy, 0);
      check("reset_flags", {overrun, timeout, wr_strobe}, 0);
      check("reset_tx_din", tx_din, 0);
      check_regs("reset_regs");

      do_frame(8'h57, 8'h03, 8'hA5, 3'b000, 0, -1);
      check_regs("write_regs");
      do_frame(8'h52, 8'h03, 8'h00, 3'b000, 0, -1);
      do_frame(8'h52, 8'h04, 8'h00, 3'b000, 0, -1);
      do_frame(8'h41, 8'h00, 8'h00, 3'b000, 0, -1);
      do_frame(8'h57, 8'h20, 8'h11, 3'b000, 0, -1);
      do_frame(8'h52, 8'h10, 8'h00, 3'b000, 0, 0);
      do_frame(8'h52, 8'h0F, 8'h00, 3'b000, 0, 0);
      check_regs("err_regs");

      // Byte arriving on the very last tick of the window is accepted.
      do_frame(8'h57, 8'h02, 8'h77, 3'b000, 0, TT - 1);
      check("boundary_timeout", timeout, 0);
      check_regs("boundary_regs");

      put_byte(8'h57, 1'b0, n);
      put_byte(8'h01, 1'b0, n);
      idle(TT);
      check("timeout_flag", timeout, 1);
      check("timeout_busy", busy, 0);
      idle(20);
      do_frame(8'h57, 8'h01, 8'h3C, 3'b000, 0, -1);
      check_regs("after_timeout_regs");

      do_frame(8'h57, 8'h05, 8'h99, 3'b100, 1, -1);
      check("overrun_flag", overrun, 1);
      check_regs("overrun_regs");

      // Reset while the read reply is being transmitted.
      put_byte(8'h52, 1'b0, n);
      put_byte(8'h03, 1'b0, n);
      e.val = mregs[3]; e.cyc = n + 2; txq.push_back(e);
      t = 0;
      while (!emu_busy && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) unexpected("wait_tx_timeout");
      reset = 1'b1;
      @(posedge clk); #1;
      check("midreset_tx_start", tx_start, 0);
      check("midreset_busy", busy, 0);
      reset = 1'b0;
      for (int i = 0; i < NREG; i++) mregs[i] = '0;
      check_regs("midreset_regs");
      check("midreset_flags", {overrun, timeout}, 0);
      idle(15);
      do_frame(8'h52, 8'h00, 8'h00, 3'b000, 0, -1);

      for (int k = 0; k < 150; k++) begin
         t = $urandom_range(0, 9);
         cmd = (t < 4) ? 8'h57 : (t < 8) ? 8'h52 : 8'($urandom);
         addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, NREG + 2));
         do_frame(cmd, addr, 8'($urandom),
                  {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)},
                  ($urandom_range(0, 9) == 0), -1);
      end
      check_regs("final_regs");
      check("txq_drained", txq.size(), 0);
      check("wq_drained", wq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
